// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: bus widths, RV32I load/store funct3 codes, FSM state enum,
// registered bus-request payload struct and the legality/alignment helpers
// used at request acceptance.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // Request fields presented on the data-side bus while a transaction is pending.
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              we;
        logic [NBYTES-1:0] wstrb;
        logic [XLEN-1:0]   wdata;
    } lsu_mem_req_t;

    // Unsigned variants only exist for loads.
    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a word-aligned one.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic lsu_access_ok(input logic we, input logic [2:0] f3,
                                           input logic [1:0] off);
        return lsu_f3_legal(we, f3) & ~lsu_misaligned(f3, off);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Handshake bundle between the execute stage, the load/store unit and the
// data-memory bus.
// Core side : req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//             rsp_valid/rsp_ready/rsp_rdata/rsp_err
// Bus side  : mem_req_valid/mem_req_ready/mem_addr/mem_we/mem_wstrb/mem_wdata,
//             mem_rsp_valid/mem_rsp_ready/mem_rdata/mem_rsp_err
// slave  modport: the load/store unit itself.
// master modport: the surrounding core + bus that drive the unit.
interface lsu_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_we;
    logic [NBYTES-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;

    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_rsp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, mem_rsp_ready
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, mem_rsp_ready
    );

endinterface

// File: rtl/lsu_load_extract.sv
// Load data extraction: selects the addressed byte/halfword/word from the
// bus read word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_funct3  in  3   load funct3 (B/H/W/BU/HU)
//   i_off     in  2   byte offset within the word
//   i_word    in  32  bus read word
//   o_data_c  out 32  extended load data (combinational)
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_data_c
);

    logic [XLEN-1:0] w_shifted;

    // Move the addressed byte lane down to bit 0.
    assign w_shifted = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data_c = w_shifted;
        case (i_funct3)
            F3_B:    o_data_c = {{24{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    o_data_c = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_data_c = {24'd0, w_shifted[7:0]};
            F3_HU:   o_data_c = {16'd0, w_shifted[15:0]};
            default: o_data_c = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencing unit. Accepts one load or store at a time from the
// execute stage, rejects illegal or misaligned accesses without touching the
// bus, otherwise issues a single word-aligned bus transaction with byte
// strobes and returns extended load data or a store completion.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  lsu_if.slave  core request/response and data-bus handshakes
// All interface outputs are registered.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_e        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_mem_req_valid;
    logic              r_mem_rsp_ready;
    lsu_mem_req_t      r_mem;

    logic              w_accept;
    logic              w_access_ok;
    logic [NBYTES-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ld_data;

    assign w_accept    = bus.req_valid & r_req_ready;
    assign w_access_ok = lsu_access_ok(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

    // Store byte strobes and lane-replicated write data for the incoming request.
    always_comb begin
        w_wstrb = '0;
        w_wdata = bus.req_wdata;
        case (bus.req_funct3)
            F3_B: begin
                w_wstrb = 4'(4'b0001 << bus.req_addr[1:0]);
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            F3_H: begin
                w_wstrb = 4'(4'b0011 << bus.req_addr[1:0]);
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            F3_W: begin
                w_wstrb = 4'b1111;
                w_wdata = bus.req_wdata;
            end
            default: begin
                w_wstrb = '0;
                w_wdata = bus.req_wdata;
            end
        endcase
    end

    lsu_load_extract u_extract (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_word   (bus.mem_rdata),
        .o_data_c (w_ld_data)
    );

    // Sequencer: IDLE -> (REQ -> WAIT ->) RESP -> IDLE, outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_we            <= 1'b0;
            r_funct3        <= 3'd0;
            r_off           <= 2'd0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_rsp_rdata     <= '0;
            r_rsp_err       <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_rsp_ready <= 1'b0;
            r_mem           <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_funct3    <= bus.req_funct3;
                        r_off       <= bus.req_addr[1:0];
                        r_req_ready <= 1'b0;
                        r_mem.addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                        if (w_access_ok) begin
                            r_mem.we        <= bus.req_we;
                            r_mem.wstrb     <= bus.req_we ? w_wstrb : '0;
                            r_mem.wdata     <= bus.req_we ? w_wdata : '0;
                            r_mem_req_valid <= 1'b1;
                            r_state         <= S_REQ;
                        end else begin
                            // Rejected access: answer directly, never reach the bus.
                            r_mem.we    <= 1'b0;
                            r_mem.wstrb <= '0;
                            r_mem.wdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end
                    end
                end

                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_rsp_ready <= 1'b1;
                        r_state         <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        r_mem_rsp_ready <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_err       <= bus.mem_rsp_err;
                        r_rsp_rdata     <= (r_we || bus.mem_rsp_err) ? '0 : w_ld_data;
                        r_state         <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_req_ready     <= 1'b1;
                    r_rsp_valid     <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                    r_mem_rsp_ready <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_rsp_ready = r_mem_rsp_ready;
    assign bus.mem_addr      = r_mem.addr;
    assign bus.mem_we        = r_mem.we;
    assign bus.mem_wstrb     = r_mem.wstrb;
    assign bus.mem_wdata     = r_mem.wdata;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing unit between the execute stage and the data-memory bus. Accepts one load or store per request handshake, checks alignment, issues one word-aligned bus transaction with byte strobes, and returns sign/zero-extended load data or a store completion. Single outstanding transaction; sits between EXU and the data-side bus port.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal funct3, or bus error
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  word address ({req_addr[31:2],2'b00})
- mem_we  out  1  bus write enable
- mem_wstrb  out  4  byte strobes (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  bus response valid
- mem_rsp_ready  out  1  unit accepts bus response
- mem_rdata  in  32  bus read word
- mem_rsp_err  in  1  bus error

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr[1:0], wdata, mem_addr. Legal funct3: loads 000/001/010/100/101, stores 000/001/010. Misaligned: H/HU/SH with addr[0]=1; W with addr[1:0]≠0. Illegal or misaligned -> RESP with err=1, rdata=0, no bus access. Otherwise -> REQ.
- REQ: mem_req_valid=1, all mem_* request fields held stable until mem_req_ready; then -> WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid: loads register extracted data, err=mem_rsp_err (rdata=0 if err); stores rdata=0, err=mem_rsp_err. -> RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; then -> IDLE. No new request accepted in RESP.
- Strobes: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111. wdata: SB {4{b}}, SH {2{h}}, SW word.
- Load extract: shift mem_rdata right by off*8; B/H sign-extend bit 7/15; BU/HU zero-extend; W unmodified.

## Timing
- Reset: state IDLE; req_ready=1; rsp_valid, mem_req_valid, mem_rsp_ready, mem_we, rsp_err =0; rsp_rdata, mem_addr, mem_wdata, mem_wstrb =0.
- Legal access, zero-wait bus: accept cycle 0; mem_req_valid cycle 1 (ready same cycle); mem_rsp_valid cycle 2; rsp_valid cycle 3. Minimum latency 3.
- Error path: accept cycle 0; rsp_valid cycle 1.
- Each bus stall cycle (mem_req_ready=0, mem_rsp_valid=0, rsp_ready=0) adds exactly one cycle; no timeout.
- mem_rsp_valid outside WAIT is ignored (mem_rsp_ready=0).
- Reset mid-operation: immediate return to IDLE with reset outputs; bus shares rst.

## Structure
- Shared package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, misalign/legal function.
- Sub-module lsu_load_extract: combinational funct3 + offset + word -> 32-bit extended result; FSM, latches, strobe/wdata generation stay in lsu_ctrl.

## Test plan
- LB addr 0x103, mem_rdata 0x80FF_0000 -> mem_addr 0x100, wstrb 0, rsp_rdata 0xFFFF_FF80, err 0, rsp_valid 3 cycles after accept.
- LHU addr 0x202, mem_rdata 0xBEEF_1234 -> rsp_rdata 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB addr 0x301 wdata 0x0000_00AB -> mem_we 1, wstrb 4'b0010, mem_wdata 0xABAB_ABAB, rsp_rdata 0.
- LW addr 0x402 -> no mem_req_valid, rsp_valid next cycle, err 1, rdata 0; funct3 3'b011 same.
- mem_req_ready low 4 cycles, rsp_ready low 2 cycles -> request/response fields stable throughout, latency 9; mem_rsp_err=1 -> rsp_err 1, rdata 0.
- rst asserted in WAIT -> next edge IDLE, req_ready 1, all valids 0; subsequent LW 0x0 completes normally.
